fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side controller for the team's synchronous first-word-fall-through FIFO: pops words and presents them on a valid/ready output stream.
- Holds a 2-entry output buffer so the stream runs at full throughput while out_ready may drop at any cycle.
- Provides a drain command that empties the FIFO and the buffer and signals completion.
- Sits between the FIFO read port and any downstream consumer, such as a serializer or bus master.

Parameters:
DATA_WIDTH  8   width of FIFO words and out_data
CNT_WIDTH   16  width of the transferred-word counter

Ports:
clk            input   1           clock, all logic on rising edge
reset_n        input   1           asynchronous active-low reset
fifo_empty     input   1           FIFO empty flag
fifo_rd_data   input   DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0
fifo_rd_en     output  1           pop request to the FIFO
enable         input   1           allow streaming pops
drain_req      input   1           single-cycle pulse, start drain
out_valid      output  1           out_data valid
out_ready      input   1           consumer accepts out_data
out_data       output  DATA_WIDTH  stream word
busy           output  1           drain in progress
drain_done     output  1           one-cycle pulse, drain complete
word_cnt       output  CNT_WIDTH   count of completed output handshakes

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Buffer cleared; buf_cnt=0; state=IDLE.
  - out_valid=0, out_data=0, fifo_rd_en=0, busy=0, drain_done=0, word_cnt=0.
- Reset mid-transfer discards buffered words. Words already popped are lost; this is by design.
- State machine (registered):
  - IDLE: enable=0. Goes to STREAM when enable=1. Goes to DRAIN when drain_req=1; drain_req has priority.
  - STREAM: goes to IDLE when enable=0. Goes to DRAIN when drain_req=1.
  - DRAIN: busy=1. Goes to DONE when fifo_empty=1, buf_cnt=0 and no pop is in progress this cycle.
  - DONE: drain_done=1 for exactly one cycle. Then goes to STREAM if enable=1, else IDLE.
  - drain_req is ignored in DRAIN and DONE.
- Pop rule (combinational from registered state):
  - fifo_rd_en = (state==STREAM or state==DRAIN) and !fifo_empty and buf_cnt<2.
  - fifo_rd_en is never asserted while fifo_empty=1.
  - On a pop edge, fifo_rd_data is written into the buffer tail.
- Buffer:
  - 2-entry in-order queue. out_valid = (buf_cnt!=0). out_data = buffer head.
  - Handshake occurs on an edge where out_valid and out_ready are both 1: the head is removed and word_cnt increments.
  - Next buf_cnt = buf_cnt + pop - handshake. A pop and a handshake in the same cycle leave buf_cnt unchanged; this is the steady state at 1 word/cycle.
- Latency: a head word present (fifo_empty=0) at edge N with fifo_rd_en=1 gives out_valid=1 after edge N. One-cycle latency.
- Stream rules:
  - Once out_valid=1, out_valid and out_data hold until the handshake, regardless of enable or state.
  - Deasserting enable stops new pops only. Buffered words still drain.
- word_cnt wraps modulo 2^CNT_WIDTH and is cleared only by reset.

Optional Feature:
- Macro FIFO_RD_PARITY_EN.
- Defined:
  - Extra output out_parity (1 bit) = XOR of all bits of the word (even parity).
  - Computed at pop time and stored per buffer entry. Resets to 0 and travels with out_data.
- Undefined: port out_parity and its storage do not exist. All other behaviour is identical.

Test Plan:
- Reset, enable=1, FIFO holds 0x11,0x22,0x33, out_ready=1 -> out_data 0x11,0x22,0x33 on 3 consecutive cycles, first out_valid one cycle after the first pop, word_cnt=3.
- Backpressure: 4 words queued, out_ready=0 for 5 cycles -> exactly 2 pops, then fifo_rd_en=0. out_data holds the first word. On out_ready=1, all 4 words arrive in order with no loss or duplicates.
- enable dropped while buf_cnt=2 -> no further pops. Both buffered words still delivered, then out_valid=0.
- enable=0, 5 words in FIFO, drain_req pulse -> busy=1, 5 words delivered. drain_done pulses once after the last handshake, then state=IDLE, busy=0. With an empty FIFO, drain_done pulses two cycles after drain_req.
- reset_n asserted with buf_cnt=2 mid-stream -> out_valid=0 immediately, word_cnt=0. After release with enable=1, the next FIFO head is delivered.
- FIFO_RD_PARITY_EN defined: words 0x03 and 0x07 -> out_parity 0 then 1, aligned with out_data under backpressure.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a first-word-fall-through FIFO into a 2-entry buffer and serves it as a valid/ready stream; drain empties FIFO and buffer.
// Latency: one cycle from a pop edge to out_valid.
// Backpressure: out_ready low holds the head word; pops stop at 2 buffered words. Define FIFO_RD_PARITY_EN to add out_parity.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  input  logic                  enable,
  input  logic                  drain_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  drain_done,
`ifdef FIFO_RD_PARITY_EN
  output logic                  out_parity,
`endif
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;
  logic                  pop;
  logic                  hs;

  // Pop only when streaming or draining, a word is available and a slot is free.
  assign pop        = ((state == ST_STREAM) || (state == ST_DRAIN)) && !fifo_empty && (buf_cnt < 2'd2);
  assign hs         = out_valid && out_ready;
  assign fifo_rd_en = pop;
  assign out_valid  = (buf_cnt != 2'd0);
  assign out_data   = buf_head;
  assign busy       = (state == ST_DRAIN);
  assign drain_done = (state == ST_DONE);

  // Next-state logic; drain_req wins over enable and is ignored once draining.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (drain_req)   state_nxt = ST_DRAIN;
        else if (enable) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (drain_req)    state_nxt = ST_DRAIN;
        else if (!enable) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (fifo_empty && (buf_cnt == 2'd0) && !pop) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = enable ? ST_STREAM : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Two-entry in-order buffer: head feeds out_data, tail holds the second word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_head <= '0;
      buf_tail <= '0;
      buf_cnt  <= 2'd0;
    end else begin
      case ({pop, hs})
        2'b10: begin
          if (buf_cnt == 2'd0) buf_head <= fifo_rd_data;
          else                 buf_tail <= fifo_rd_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_head <= buf_tail;
          buf_cnt  <= buf_cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new word lands behind whatever remains.
          if (buf_cnt == 2'd2) begin
            buf_head <= buf_tail;
            buf_tail <= fifo_rd_data;
          end else begin
            buf_head <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_PARITY_EN
  logic par_head;
  logic par_tail;
  logic par_in;

  assign par_in     = ^fifo_rd_data;
  assign out_parity = par_head;

  // Parity bits follow their data words through the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_head <= 1'b0;
      par_tail <= 1'b0;
    end else begin
      case ({pop, hs})
        2'b10: begin
          if (buf_cnt == 2'd0) par_head <= par_in;
          else                 par_tail <= par_in;
        end
        2'b01: par_head <= par_tail;
        2'b11: begin
          if (buf_cnt == 2'd2) begin
            par_head <= par_tail;
            par_tail <= par_in;
          end else begin
            par_head <= par_in;
          end
        end
        default: ;
      endcase
    end
  end
`endif

  // Completed-handshake counter, wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) word_cnt <= '0;
    else if (hs)  word_cnt <= word_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO and stream behaviour modelled with queues.
// Directed scenarios followed by a randomized phase and a final drain.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int M_IDLE = 0, M_STREAM = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, fifo_empty, fifo_rd_en, enable, drain_req;
  logic          out_valid, out_ready, busy, drain_done;
  logic [DW-1:0] fifo_rd_data, out_data;
  logic [CW-1:0] word_cnt;
`ifdef FIFO_RD_PARITY_EN
  logic          out_parity;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .enable(enable), .drain_req(drain_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .drain_done(drain_done),
`ifdef FIFO_RD_PARITY_EN
    .out_parity(out_parity),
`endif
    .word_cnt(word_cnt)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  mdl_buf[$];
  logic [7:0]  exp_q[$];
  int          mdl_mode;
  logic [15:0] mdl_cnt;
  int          dut_pops, dut_hs, tot_pushed, tot_discarded;
  logic        obs_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    tot_pushed++;
    drive_fifo();
  endtask

  // One clock: check outputs against the model, then advance the model over the edge.
  task automatic tick();
    bit         exp_pop, exp_vld, hs;
    int         sz;
    logic [7:0] head;
    @(negedge clk);
    sz      = mdl_buf.size();
    exp_pop = ((mdl_mode == M_STREAM) || (mdl_mode == M_DRAIN)) && (fifo_q.size() > 0) && (sz < 2);
    exp_vld = (sz != 0);
    head    = exp_vld ? mdl_buf[0] : 8'h00;
    if (fifo_rd_en === 1'b1) dut_pops++;
    if (out_valid === 1'b1 && out_ready) dut_hs++;
    obs_done = drain_done;
    chk("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_pop});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
    if (exp_vld) chk("out_data", {24'd0, out_data}, {24'd0, head});
`ifdef FIFO_RD_PARITY_EN
    if (exp_vld) chk("out_parity", {31'd0, out_parity}, {31'd0, ^head});
`endif
    chk("busy", {31'd0, busy}, {31'd0, mdl_mode == M_DRAIN});
    chk("drain_done", {31'd0, drain_done}, {31'd0, mdl_mode == M_DONE});
    chk("word_cnt", {16'd0, word_cnt}, {16'd0, mdl_cnt});
    hs = exp_vld && out_ready;
    if (hs) begin
      if (exp_q.size() != 0) begin
        chk("stream_order", {24'd0, out_data}, {24'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end else begin
        chk("stream_extra_word", 32'd1, 32'd0);
      end
      void'(mdl_buf.pop_front());
      mdl_cnt++;
    end
    case (mdl_mode)
      M_IDLE:   if (drain_req) mdl_mode = M_DRAIN; else if (enable) mdl_mode = M_STREAM;
      M_STREAM: if (drain_req) mdl_mode = M_DRAIN; else if (!enable) mdl_mode = M_IDLE;
      M_DRAIN:  if (fifo_q.size() == 0 && sz == 0) mdl_mode = M_DONE;
      default:  mdl_mode = enable ? M_STREAM : M_IDLE;
    endcase
    if (exp_pop) mdl_buf.push_back(fifo_q.pop_front());
    @(posedge clk);
    #1;
    drain_req = 1'b0;
    drive_fifo();
  endtask

  task automatic do_reset_mid();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    chk("rst_fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    tot_discarded += mdl_buf.size();
    repeat (mdl_buf.size()) void'(exp_q.pop_front());
    mdl_buf.delete();
    mdl_cnt  = '0;
    mdl_mode = M_IDLE;
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive_fifo();
  endtask

  initial begin
    int p0, h0;
    reset_n = 1'b0; enable = 1'b0; drain_req = 1'b0; out_ready = 1'b0;
    mdl_mode = M_IDLE; mdl_cnt = '0;
    dut_pops = 0; dut_hs = 0; tot_pushed = 0; tot_discarded = 0; obs_done = 1'b0;
    drive_fifo();
    #3;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_drain_done", {31'd0, drain_done}, 32'd0);
    chk("reset_word_cnt", {16'd0, word_cnt}, 32'd0);
    chk("reset_out_data", {24'd0, out_data}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic streaming of three words at full rate.
    push(8'h11); push(8'h22); push(8'h33);
    enable = 1'b1; out_ready = 1'b1;
    repeat (6) tick();
    chk("s1_word_cnt", {16'd0, word_cnt}, 32'd3);

    // Backpressure: only two pops while the consumer stalls.
    out_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    p0 = dut_pops;
    repeat (5) tick();
    chk("bp_pops", p0 == 0 ? dut_pops : dut_pops - p0, 32'd2);
    chk("bp_hold", {24'd0, out_data}, 32'hA1);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("bp_word_cnt", {16'd0, word_cnt}, 32'd7);

    // Dropping enable with a full buffer stops pops but not delivery.
    out_ready = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    repeat (3) tick();
    enable = 1'b0;
    p0 = dut_pops;
    repeat (3) tick();
    chk("en_off_pops", dut_pops - p0, 32'd0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("en_off_empty", {31'd0, out_valid}, 32'd0);
    chk("en_off_word_cnt", {16'd0, word_cnt}, 32'd9);

    // Drain five words with enable low.
    push(8'hC1); push(8'hC2); push(8'hC3);
    h0 = dut_hs;
    drain_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (obs_done) break;
    end
    chk("drain_seen", {31'd0, obs_done}, 32'd1);
    chk("drain_words", dut_hs - h0, 32'd5);
    tick();
    chk("drain_done_once", {31'd0, obs_done}, 32'd0);
    chk("drain_idle_busy", {31'd0, busy}, 32'd0);

    // Drain of an empty FIFO completes two cycles after the request.
    drain_req = 1'b1;
    tick(); tick();
    chk("empty_drain_early", {31'd0, obs_done}, 32'd0);
    tick();
    chk("empty_drain_done", {31'd0, obs_done}, 32'd1);
    tick();

    // Reset with two words buffered, then resume.
    enable = 1'b1; out_ready = 1'b0;
    push(8'hD1); push(8'hD2); push(8'hD3);
    repeat (4) tick();
    do_reset_mid();
    enable = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_word_cnt", {16'd0, word_cnt}, 32'd1);

`ifdef FIFO_RD_PARITY_EN
    out_ready = 1'b0;
    push(8'h03); push(8'h07);
    repeat (3) tick();
    chk("par_first", {31'd0, out_parity}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("par_second_data", {24'd0, out_data}, 32'h07);
    chk("par_second", {31'd0, out_parity}, 32'd1);
    repeat (2) tick();
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 8) push(8'($urandom_range(0, 255)));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) drain_req = 1'b1;
      tick();
    end

    // Final drain: everything pushed and not discarded must have come out.
    enable = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    drain_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (obs_done) break;
    end
    chk("final_drain_seen", {31'd0, obs_done}, 32'd1);
    chk("no_loss", dut_hs, tot_pushed - tot_discarded);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
